// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud constant and frame width.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int BAUD_9600 = 10416;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: detects the start edge, samples each bit at mid-bit and
// strobes o_valid for a good stop bit or o_frame_err for a bad one.
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_9600,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev;
  state_t               state;
  state_t               next_state;
  logic [CW-1:0]        count;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 count_clr;
  logic                 sample_bit;
  logic                 good_stop;
  logic                 bad_stop;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  always_comb begin
    next_state = state;
    count_clr  = 1'b0;
    sample_bit = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a fresh 1->0 edge starts a frame, so a held-low break cannot retrigger.
        if (rx_prev && !rx_s) next_state = S_START;
      end
      S_START: begin
        if (count == HALF_LAST) next_state = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (count == BIT_LAST) begin
          sample_bit = 1'b1;
          count_clr  = 1'b1;
          if (bit_idx == IDX_LAST) next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (count == BIT_LAST) begin
          next_state = S_IDLE;
          good_stop  = rx_s;
          bad_stop   = !rx_s;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_IDLE;
      rx_prev     <= 1'b1;
      count       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state   <= next_state;
      rx_prev <= rx_s;
      count   <= (count_clr || next_state != state) ? '0 : count + CW'(1);
      if (state == S_START && next_state == S_DATA) bit_idx <= '0;
      else if (sample_bit)                          bit_idx <= bit_idx + IW'(1);
      if (sample_bit) shift[bit_idx] <= rx_s;
      if (good_stop) o_data <= shift;
      o_valid     <= good_stop;
      o_frame_err <= bad_stop;
      // Registered from next_state so o_busy lines up exactly with the state register.
      o_busy      <= (next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm at 16 clocks per bit with a behavioural transmitter.
module tb_uart_rx_fsm;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int start_cyc = 0;
  int v0, e0, lat;
  logic [7:0] got[$];

  uart_rx_fsm #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      got.push_back(data);
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic stop);
    start_cyc = cyc;
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    hold(1'b1, 200);
    check("idle_valid_cnt", valid_cnt, 0);
    check("idle_err_cnt", err_cnt, 0);

    // Single byte and start-edge-to-valid latency
    tx_frame(8'hA5, 1'b1);
    hold(1'b1, 20);
    check("a5_valid_cnt", valid_cnt, 1);
    check("a5_data", data, 8'hA5);
    check("a5_err_cnt", err_cnt, 0);
    lat = valid_cyc - start_cyc;
    total++;
    assert (lat >= 154 && lat <= 156) else begin
      bad++;
      $error("[TB] FAIL a5_latency observed=%0d expected=155+-1", lat);
    end

    // Back-to-back frames, one stop bit each
    got.delete();
    v0 = valid_cnt;
    tx_frame(8'h00, 1'b1);
    tx_frame(8'hFF, 1'b1);
    tx_frame(8'h55, 1'b1);
    tx_frame(8'h3C, 1'b1);
    hold(1'b1, 20);
    check("loop_valid_cnt", valid_cnt - v0, 4);
    check("loop_q_size", got.size(), 4);
    if (got.size() == 4) begin
      check("loop_b0", got[0], 8'h00);
      check("loop_b1", got[1], 8'hFF);
      check("loop_b2", got[2], 8'h55);
      check("loop_b3", got[3], 8'h3C);
    end

    // Framing error keeps the previous byte
    v0 = valid_cnt;
    e0 = err_cnt;
    tx_frame(8'h81, 1'b0);
    hold(1'b1, 20);
    check("ferr_err_cnt", err_cnt - e0, 1);
    check("ferr_valid_cnt", valid_cnt - v0, 0);
    check("ferr_data_hold", data, 8'h3C);
    tx_frame(8'h42, 1'b1);
    hold(1'b1, 20);
    check("after_ferr_data", data, 8'h42);
    check("after_ferr_valid", valid_cnt - v0, 1);

    // Short glitch must not produce any pulse
    v0 = valid_cnt;
    e0 = err_cnt;
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_busy", busy, 1'b0);

    // Break: one frame error, then silence while the line stays low
    hold(1'b0, 400);
    check("break_err", err_cnt - e0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_busy", busy, 1'b0);
    hold(1'b1, 40);
    check("break_release_err", err_cnt - e0, 1);

    // Reset during D3 of 8'hC3
    v0 = valid_cnt;
    e0 = err_cnt;
    hold(1'b0, CPB);
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB);
    hold(1'b0, CPB / 2);
    check("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", valid, 1'b0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(1'b1, 30);
    check("midrst_data", data, 8'h00);
    check("midrst_no_pulse", (valid_cnt - v0) + (err_cnt - e0), 0);
    tx_frame(8'h99, 1'b1);
    hold(1'b1, 20);
    check("post_rst_data", data, 8'h99);
    check("post_rst_valid", valid_cnt - v0, 1);
    check("post_rst_err", err_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
